// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register and ALU operand-select stage.
//
// Operands are resolved from three forwarding sources before they are
// registered. In priority order these are:
//   1. the instruction now in EX (alu_result)
//   2. EX/MEM (ex_mem_result)
//   3. MEM/WB (mem_wb_result)
// If none of them matches, the register-file read data is used.
//
// A load-use dependency raises the combinational stall and loads a bubble.
// A flush also loads a bubble, and it suppresses the stall.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   id_*                     decoded instruction fields from the ID stage
//   alu_result               combinational ALU output of the EX instruction
//   ex_mem_*, mem_wb_*       later-stage destination / write info for forwarding
//   flush                    discard the instruction being captured
//   input1, input2, Ctrl_alu registered ALU operands and op code
//   ex_rd, ex_reg_write,
//   ex_mem_read, ex_valid    registered EX-stage controls
//   ex_rt_data               forwarded rt value (store data)
//   stall                    combinational; holds PC and IF/ID when high
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_rs_used,
  input  logic          id_rt_used,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_shamt,
  input  logic          id_use_imm,
  input  logic          id_use_shamt,
  input  logic [3:0]    id_ctrl_alu,
  input  logic [RW-1:0] id_rd,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic [DW-1:0] alu_result,
  input  logic [RW-1:0] ex_mem_rd,
  input  logic          ex_mem_reg_write,
  input  logic          ex_mem_mem_read,
  input  logic [DW-1:0] ex_mem_result,
  input  logic [RW-1:0] mem_wb_rd,
  input  logic          mem_wb_reg_write,
  input  logic [DW-1:0] mem_wb_result,
  input  logic          flush,
  output logic [DW-1:0] input1,
  output logic [DW-1:0] input2,
  output logic [3:0]    Ctrl_alu,
  output logic [RW-1:0] ex_rd,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_valid,
  output logic [DW-1:0] ex_rt_data,
  output logic          stall
);

  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;
  logic [DW-1:0] sel_in1;
  logic [DW-1:0] sel_in2;
  logic          hazard_rs;
  logic          hazard_rt;
  logic          bubble;

  // Forwarded rs value. Register 0 is hardwired, so it is never forwarded.
  // When several sources match, the youngest one wins.
  always_comb begin
    fwd_rs = id_rs_data;
    if (id_rs != '0) begin
      if (ex_reg_write && ex_valid && (ex_rd == id_rs))
        fwd_rs = alu_result;
      else if (ex_mem_reg_write && (ex_mem_rd == id_rs))
        fwd_rs = ex_mem_result;
      else if (mem_wb_reg_write && (mem_wb_rd == id_rs))
        fwd_rs = mem_wb_result;
    end
  end

  // Forwarded rt value, with the same priority as rs.
  always_comb begin
    fwd_rt = id_rt_data;
    if (id_rt != '0) begin
      if (ex_reg_write && ex_valid && (ex_rd == id_rt))
        fwd_rt = alu_result;
      else if (ex_mem_reg_write && (ex_mem_rd == id_rt))
        fwd_rt = ex_mem_result;
      else if (mem_wb_reg_write && (mem_wb_rd == id_rt))
        fwd_rt = mem_wb_result;
    end
  end

  // A load's data only exists once the load reaches MEM/WB.
  // A load in EX therefore costs two bubbles, and a load in EX/MEM costs one.
  assign hazard_rs = id_rs_used && (id_rs != '0) &&
                     ((ex_valid && ex_mem_read && (ex_rd == id_rs)) ||
                      (ex_mem_mem_read && ex_mem_reg_write && (ex_mem_rd == id_rs)));

  assign hazard_rt = id_rt_used && (id_rt != '0) &&
                     ((ex_valid && ex_mem_read && (ex_rd == id_rt)) ||
                      (ex_mem_mem_read && ex_mem_reg_write && (ex_mem_rd == id_rt)));

  // Flush wins over stall: a flushed instruction never needs to wait.
  assign stall  = id_valid && !flush && (hazard_rs || hazard_rt);
  assign bubble = flush || stall || !id_valid;

  assign sel_in1 = id_use_shamt ? {{(DW-5){1'b0}}, id_shamt} : fwd_rs;
  assign sel_in2 = id_use_imm ? id_imm : fwd_rt;

  // Pipeline register. A bubble clears every field, so a stalled or flushed
  // slot looks exactly like the reset state to downstream stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      input1       <= '0;
      input2       <= '0;
      Ctrl_alu     <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_valid     <= 1'b0;
      ex_rt_data   <= '0;
    end else if (bubble) begin
      input1       <= '0;
      input2       <= '0;
      Ctrl_alu     <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_valid     <= 1'b0;
      ex_rt_data   <= '0;
    end else begin
      input1       <= sel_in1;
      input2       <= sel_in2;
      Ctrl_alu     <= id_ctrl_alu;
      ex_rd        <= id_rd;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
      ex_valid     <= 1'b1;
      ex_rt_data   <= fwd_rt;
    end
  end

endmodule
